kitchen_timer_ctrl: RTL and testbench
=====================================

# kitchen_timer_ctrl

Control FSM for the kitchen timer. It owns the mm:ss countdown value and sequences the 1 Hz prescaler (`clk_div16`): it starts, pauses and clears the prescaler, and consumes the prescaler's tick output. It also handles set, run, pause and alarm behaviour from debounced single-cycle button pulses. It sits between the button conditioning logic and the 7-segment display driver.

## Interface

**Parameters**
- `ALARM_SECS`, default 10: number of ticks the alarm stays asserted before auto-return to IDLE (1..255).
- `TICK_EDGE`, default 1: 1 = count on rising edge of `tick`; 0 = count on every cycle `tick` is high.

**Ports**
- `clk_in` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: prescaler output (`clk_div16` `clk_out`). Its high level may last more than one cycle.
- `btn_start_stop` input 1: one-cycle pulse.
- `btn_clear` input 1: one-cycle pulse.
- `btn_inc_min` input 1: one-cycle pulse.
- `btn_inc_sec` input 1: one-cycle pulse.
- `div_start` output 1: enable to the prescaler `start`.
- `div_reset` output 1: one-cycle clear pulse to the prescaler `reset`.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD display digits.
- `running` output 1: high in RUN.
- `alarm` output 1: high in ALARM.
- `state` output 2: current FSM state, for debug.

## Operation

**States:** IDLE=0, RUN=1, PAUSE=2, ALARM=3.

**IDLE**
- `btn_inc_min`: minutes +1, 00..99; 99 wraps to 00.
- `btn_inc_sec`: seconds +1, 00..59; 59 wraps to 00. There is no carry into minutes.
- Both increment pulses in the same cycle: both apply.
- `btn_clear`: value becomes 00:00.
- `btn_start_stop` with value != 00:00: go to RUN and pulse `div_reset` once.
- `btn_start_stop` with value == 00:00: ignored.

**RUN**
- `div_start`=1.
- On each tick event the value decrements: ss-1; ss 00 becomes 59 with mm-1.
- A decrement that reaches 00:00 moves the FSM to ALARM on the same edge.
- `btn_start_stop`: go to PAUSE.
- Increment buttons are ignored.

**PAUSE**
- `div_start`=0, so the prescaler holds its phase.
- Tick events are ignored.
- `btn_start_stop`: go to RUN. No `div_reset` is issued, so the partial second is preserved.
- Increment buttons are ignored.

**ALARM**
- `alarm`=1, `div_start`=1, value stays 00:00.
- An 8-bit counter counts tick events; at `ALARM_SECS` the FSM returns to IDLE.
- `btn_start_stop` or `btn_clear`: go to IDLE immediately.

**Clear and priority**
- `btn_clear` in any state goes to IDLE, sets the value to 00:00 and pulses `div_reset`.
- Priority: `reset` > `btn_clear` > tick-driven transition > `btn_start_stop` > increments.

**Tick event**
- With `TICK_EDGE`=1: `tick & ~tick_q`, where `tick_q` is `tick` registered on `clk_in`.
- A held-high `tick` (prescaler paused at its terminal count) counts once only.

## Timing

**Registers and reset values**
- All outputs are registered.
- On `reset`:
  - state = IDLE;
  - digits = 0;
  - `div_start`, `div_reset`, `running`, `alarm` = 0;
  - `tick_q` = 0;
  - alarm counter = 0.

**Latencies**
- Button pulse at edge N: state, digits and `div_start` change at edge N (visible in cycle N+1).
- `div_reset`:
  - high for exactly one cycle, in the cycle after the start/clear pulse;
  - the prescaler therefore restarts from 0 and the first counted second is full length.
- Tick event: digits update one cycle after `tick` rises. `running` drops in the same cycle `alarm` rises.

**Simultaneous events**
- Tick and `btn_start_stop` in the same cycle in RUN: the decrement applies first.
  - If the value reaches 00:00, go to ALARM; the start/stop press is dropped.
  - Otherwise go to PAUSE with the decremented value.
- `reset` asserted mid-RUN: immediate return to reset values. The programmed time is lost.

## Structure

**Shared include `timer_defs.vh`**
- State encodings.
- BCD digit width (4).
- Digit limits `SEC_TENS_MAX`=5, `DIGIT_MAX`=9, `MIN_MAX`=99.

**Sub-module `bcd_mmss_counter`**
- Four BCD digit registers.
- Operations: inc_min, inc_sec, dec (with borrow), clear.
- `is_zero` output.
- Keeps BCD arithmetic out of the FSM.

## Test plan

- Set and run: reset, then 1×`btn_inc_min`, 5×`btn_inc_sec`, `btn_start_stop`.
  - Required: display 01:05 and one `div_reset` pulse.
  - After 6 ticks: 00:59.
  - After 59 more: 00:00, with `alarm`=1 and `running`=0.
- Wrap in IDLE: 100×`btn_inc_min` → 00; 60×`btn_inc_sec` → 00. No carry into minutes.
- Pause: start at 00:10, 3 ticks → 00:07, `btn_start_stop` → PAUSE with `div_start`=0.
  - 5 ticks while paused: display stays 00:07.
  - Resume with no `div_reset`; next tick → 00:06.
- Held tick: `tick` high for 20 cycles in RUN → exactly one decrement.
- Simultaneous: at 00:01, tick and `btn_start_stop` in the same cycle → ALARM, not PAUSE.
  - `btn_clear` together with `btn_start_stop` in RUN → IDLE at 00:00.
- Alarm timeout: with `ALARM_SECS`=3, `alarm` is high for exactly 3 tick events, then IDLE.
  - Async `reset` mid-RUN: all outputs zero within the same cycle.

Source files
------------

// File: rtl/kitchen_timer_ctrl_pkg.sv
// Shared definitions for the kitchen timer: state encoding, BCD digit limits
// and a small BCD increment helper.
package kitchen_timer_ctrl_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t        SEC_TENS_MAX = 4'd5;
    localparam bcd_t        DIGIT_MAX    = 4'd9;
    localparam int unsigned MIN_MAX      = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t max);
        return (d == max) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/kitchen_timer_ctrl_bcd_mmss_counter.sv
// mm:ss value held as four BCD digits; supports clear, independent minute and
// second increments (no carry between them) and a borrowing decrement.
module bcd_mmss_counter
    import kitchen_timer_ctrl_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       dec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       is_zero,
    output logic       is_one
);

    logic [7:0] min_bin;

    assign min_bin = ({4'd0, min_tens} * 8'd10) + {4'd0, min_ones};
    assign is_zero = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
    assign is_one  = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == 4'd1);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else if (clr) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else if (dec) begin
            // Borrow ripples ss -> mm; a request at 00:00 is ignored.
            if (!is_zero) begin
                if (sec_ones != '0) begin
                    sec_ones <= sec_ones - 4'd1;
                end else begin
                    sec_ones <= DIGIT_MAX;
                    if (sec_tens != '0) begin
                        sec_tens <= sec_tens - 4'd1;
                    end else begin
                        sec_tens <= SEC_TENS_MAX;
                        if (min_ones != '0) begin
                            min_ones <= min_ones - 4'd1;
                        end else begin
                            min_ones <= DIGIT_MAX;
                            min_tens <= min_tens - 4'd1;
                        end
                    end
                end
            end
        end else begin
            if (inc_min) begin
                if (min_bin == 8'(MIN_MAX)) begin
                    min_tens <= '0;
                    min_ones <= '0;
                end else begin
                    min_ones <= bcd_inc(min_ones, DIGIT_MAX);
                    if (min_ones == DIGIT_MAX)
                        min_tens <= min_tens + 4'd1;
                end
            end
            if (inc_sec) begin
                sec_ones <= bcd_inc(sec_ones, DIGIT_MAX);
                if (sec_ones == DIGIT_MAX)
                    sec_tens <= bcd_inc(sec_tens, SEC_TENS_MAX);
            end
        end
    end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer control FSM: sequences the 1 Hz prescaler, consumes its tick,
// and drives the mm:ss countdown plus run/alarm status.
module kitchen_timer_ctrl
    import kitchen_timer_ctrl_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 10,
    parameter bit          TICK_EDGE  = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    output logic       div_start,
    output logic       div_reset,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    state_t     state_q, state_nx;
    logic       tick_q, tick_ev;
    logic [7:0] alarm_cnt_q, alarm_cnt_nx;
    logic       ctr_clr, ctr_inc_min, ctr_inc_sec, ctr_dec;
    logic       div_reset_nx;
    logic       is_zero, is_one;

    assign tick_ev = TICK_EDGE ? (tick & ~tick_q) : tick;
    assign state   = state_q;

    bcd_mmss_counter u_counter (
        .clk_in   (clk_in),
        .reset    (reset),
        .clr      (ctr_clr),
        .inc_min  (ctr_inc_min),
        .inc_sec  (ctr_inc_sec),
        .dec      (ctr_dec),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .is_zero  (is_zero),
        .is_one   (is_one)
    );

    always_comb begin
        state_nx     = state_q;
        alarm_cnt_nx = alarm_cnt_q;
        ctr_clr      = 1'b0;
        ctr_inc_min  = 1'b0;
        ctr_inc_sec  = 1'b0;
        ctr_dec      = 1'b0;
        div_reset_nx = 1'b0;
        if (btn_clear) begin
            state_nx     = ST_IDLE;
            ctr_clr      = 1'b1;
            div_reset_nx = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_start_stop && !is_zero) begin
                        state_nx     = ST_RUN;
                        div_reset_nx = 1'b1;
                    end else begin
                        ctr_inc_min = btn_inc_min;
                        ctr_inc_sec = btn_inc_sec;
                    end
                end
                ST_RUN: begin
                    // A tick that lands on 00:00 swallows a same-cycle start/stop.
                    if (tick_ev) begin
                        ctr_dec = 1'b1;
                        if (is_one) begin
                            state_nx     = ST_ALARM;
                            alarm_cnt_nx = '0;
                        end else if (btn_start_stop) begin
                            state_nx = ST_PAUSE;
                        end
                    end else if (btn_start_stop) begin
                        state_nx = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (btn_start_stop)
                        state_nx = ST_RUN;
                end
                ST_ALARM: begin
                    if (tick_ev)
                        alarm_cnt_nx = alarm_cnt_q + 8'd1;
                    if ((tick_ev && (alarm_cnt_q + 8'd1 == 8'(ALARM_SECS))) || btn_start_stop)
                        state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tick_q      <= 1'b0;
            alarm_cnt_q <= '0;
            div_start   <= 1'b0;
            div_reset   <= 1'b0;
            running     <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state_q     <= state_nx;
            tick_q      <= tick;
            alarm_cnt_q <= alarm_cnt_nx;
            div_reset   <= div_reset_nx;
            div_start   <= (state_nx == ST_RUN) || (state_nx == ST_ALARM);
            running     <= (state_nx == ST_RUN);
            alarm       <= (state_nx == ST_ALARM);
        end
    end

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Bench for kitchen_timer_ctrl: vector table, directed corner sequences and
// random stimulus against a seconds-based reference model.
module tb_kitchen_timer_ctrl;

    localparam int unsigned ALARM_N = 3;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       tick, btn_start_stop, btn_clear, btn_inc_min, btn_inc_sec;
    logic       div_start, div_reset, running, alarm;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // reference model: value as whole minutes/seconds, state as spec number
    int m_st, m_mm, m_ss, m_acnt;
    bit m_dr, m_tprev;

    always #5 clk_in = ~clk_in;

    kitchen_timer_ctrl #(.ALARM_SECS(ALARM_N), .TICK_EDGE(1'b1)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .tick           (tick),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_inc_min    (btn_inc_min),
        .btn_inc_sec    (btn_inc_sec),
        .div_start      (div_start),
        .div_reset      (div_reset),
        .min_tens       (min_tens),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .running        (running),
        .alarm          (alarm),
        .state          (state)
    );

    typedef struct {
        logic        t, s, c, im, is;
        logic [15:0] exp_digits;
        logic [1:0]  exp_state;
        logic        exp_dr;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_mm = 0; m_ss = 0; m_acnt = 0; m_dr = 0; m_tprev = 0;
    endtask

    task automatic model_edge(input logic t, input logic s, input logic c, input logic im, input logic is);
        bit ev;
        int tot;
        ev = t && !m_tprev;
        m_tprev = t;
        m_dr = 0;
        if (c) begin
            m_st = 0; m_mm = 0; m_ss = 0; m_dr = 1;
        end else begin
            case (m_st)
                0: begin
                    if (s && (m_mm != 0 || m_ss != 0)) begin
                        m_st = 1; m_dr = 1;
                    end else begin
                        if (im) m_mm = (m_mm + 1) % 100;
                        if (is) m_ss = (m_ss + 1) % 60;
                    end
                end
                1: begin
                    if (ev) begin
                        tot  = m_mm * 60 + m_ss - 1;
                        m_mm = tot / 60;
                        m_ss = tot % 60;
                        if (tot == 0) begin
                            m_st = 3; m_acnt = 0;
                        end else if (s) m_st = 2;
                    end else if (s) m_st = 2;
                end
                2: if (s) m_st = 1;
                default: begin
                    if (ev) m_acnt++;
                    if ((ev && m_acnt == ALARM_N) || s) m_st = 0;
                end
            endcase
        end
    endtask

    task automatic check_model();
        logic [15:0] ed;
        logic [3:0]  ef;
        ed = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
        ef = {(m_st == 1 || m_st == 3), m_dr, (m_st == 1), (m_st == 3)};
        chk("model_digits", 32'(digits()), 32'(ed));
        chk("model_state", 32'(state), 32'(m_st));
        chk("model_flags{start,dreset,run,alarm}", 32'({div_start, div_reset, running, alarm}), 32'(ef));
    endtask

    task automatic step(input logic t, input logic s, input logic c, input logic im, input logic is);
        @(negedge clk_in);
        tick = t; btn_start_stop = s; btn_clear = c; btn_inc_min = im; btn_inc_sec = is;
        @(posedge clk_in);
        model_edge(t, s, c, im, is);
        #1 check_model();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0); endtask

    task automatic tick_pulse(); step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); endtask

    task automatic do_reset();
        @(negedge clk_in);
        tick = 0; btn_start_stop = 0; btn_clear = 0; btn_inc_min = 0; btn_inc_sec = 0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("reset_outputs", 32'({div_start, div_reset, running, alarm, state, digits()}), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        logic tl;
        reset = 1'b0;
        tick = 0; btn_start_stop = 0; btn_clear = 0; btn_inc_min = 0; btn_inc_sec = 0;
        model_reset();

        tbl[0] = '{t:0, s:0, c:0, im:1, is:0, exp_digits:16'h0100, exp_state:2'd0, exp_dr:0};
        tbl[1] = '{t:0, s:0, c:0, im:0, is:1, exp_digits:16'h0101, exp_state:2'd0, exp_dr:0};
        tbl[2] = '{t:0, s:0, c:0, im:0, is:1, exp_digits:16'h0102, exp_state:2'd0, exp_dr:0};
        tbl[3] = '{t:0, s:0, c:0, im:0, is:1, exp_digits:16'h0103, exp_state:2'd0, exp_dr:0};
        tbl[4] = '{t:0, s:0, c:0, im:0, is:1, exp_digits:16'h0104, exp_state:2'd0, exp_dr:0};
        tbl[5] = '{t:0, s:0, c:0, im:0, is:1, exp_digits:16'h0105, exp_state:2'd0, exp_dr:0};
        tbl[6] = '{t:0, s:1, c:0, im:0, is:0, exp_digits:16'h0105, exp_state:2'd1, exp_dr:1};
        tbl[7] = '{t:0, s:0, c:0, im:0, is:0, exp_digits:16'h0105, exp_state:2'd1, exp_dr:0};

        // set and run
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].t, tbl[i].s, tbl[i].c, tbl[i].im, tbl[i].is);
            chk("vec_digits", 32'(digits()), 32'(tbl[i].exp_digits));
            chk("vec_state", 32'(state), 32'(tbl[i].exp_state));
            chk("vec_div_reset", 32'(div_reset), 32'(tbl[i].exp_dr));
        end
        repeat (6) tick_pulse();
        chk("after6_digits", 32'(digits()), 32'h0059);
        repeat (59) tick_pulse();
        chk("expire_digits", 32'(digits()), 32'h0000);
        chk("expire_alarm_run", 32'({alarm, running}), 32'b10);
        for (int i = 1; i <= int'(ALARM_N); i++) begin
            tick_pulse();
            if (i < int'(ALARM_N)) chk("alarm_held", 32'(alarm), 32'd1);
        end
        chk("alarm_timeout_state", 32'(state), 32'd0);
        chk("alarm_timeout_flag", 32'(alarm), 32'd0);

        // wrap in IDLE
        do_reset();
        repeat (99) step(0, 0, 0, 1, 0);
        chk("min_99", 32'(digits()), 32'h9900);
        step(0, 0, 0, 1, 0);
        chk("min_wrap", 32'(digits()), 32'h0000);
        repeat (59) step(0, 0, 0, 0, 1);
        chk("sec_59", 32'(digits()), 32'h0059);
        step(0, 0, 0, 0, 1);
        chk("sec_wrap_no_carry", 32'(digits()), 32'h0000);

        // pause and resume
        do_reset();
        repeat (10) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle();
        repeat (3) tick_pulse();
        chk("pause_pre", 32'(digits()), 32'h0007);
        step(0, 1, 0, 0, 0);
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_div_start", 32'(div_start), 32'd0);
        repeat (5) tick_pulse();
        chk("pause_hold", 32'(digits()), 32'h0007);
        step(0, 1, 0, 0, 0);
        chk("resume_no_div_reset", 32'({state, div_reset, div_start}), 32'b0101);
        tick_pulse();
        chk("resume_tick", 32'(digits()), 32'h0006);

        // held tick
        repeat (20) step(1, 0, 0, 0, 0);
        idle();
        chk("held_tick", 32'(digits()), 32'h0005);

        // tick and start/stop together at 00:01
        do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle();
        step(1, 1, 0, 0, 0);
        chk("simul_alarm", 32'(state), 32'd3);
        step(0, 0, 1, 0, 0);
        chk("clear_from_alarm", 32'({state, div_reset}), 32'b001);

        // clear together with start/stop in RUN
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle();
        step(0, 1, 1, 0, 0);
        chk("clear_beats_start", 32'({state, div_reset, digits()}), 32'h10000);

        // async reset mid-RUN
        repeat (5) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle();
        @(posedge clk_in);
        #3 reset = 1'b1;
        #1 chk("async_reset", 32'({div_start, div_reset, running, alarm, state, digits()}), 32'd0);
        model_reset();
        @(negedge clk_in);
        reset = 1'b0;

        // random traffic
        tl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) tl = ~tl;
            step(tl,
                 ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 90) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
